// File: rtl/prog_loader_pkg.sv
// prog_loader shared types: FSM states and byte/word/length widths.
// Checksum stage is enabled by defining PROG_LOADER_CHECKSUM_EN.
package prog_loader_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LEN_W  = 16;
  localparam int CNT_W  = LEN_W + 1;
  localparam int BPW    = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CHECK,
    DONE,
    ERROR
  } state_t;

  function automatic logic rx_state(input state_t s);
    return s inside {LEN_HI, LEN_LO, DATA, CHECK};
  endfunction

endpackage

// File: rtl/prog_loader_word_packer.sv
// prog_word_packer: little-endian byte-to-word assembly for prog_loader.
// Emits the finished word with a one-cycle word_valid after the 4th byte.
module prog_word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_in,
  input  logic              byte_valid,
  output logic              last,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  localparam int IDX_W = $clog2(BPW);

  logic [IDX_W-1:0]         idx;
  logic [WORD_W-BYTE_W-1:0] acc;

  assign last = (idx == IDX_W'(BPW - 1));

  // bytes shift in from the top so the first one lands in bits 7:0
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx        <= '0;
      acc        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clear) begin
        idx <= '0;
      end else if (byte_valid) begin
        acc <= {byte_in, acc[WORD_W-BYTE_W-1:BYTE_W]};
        idx <= idx + 1'b1;
        if (last) begin
          word       <= {byte_in, acc};
          word_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// prog_loader: streams a length-prefixed image into program memory.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing XOR check byte.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MAX_WORDS = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err
);

  state_t           st;
  state_t           nxt;
  logic [LEN_W-1:0] len;
  logic [LEN_W-1:0] len_in;
  logic [CNT_W-1:0] wcnt;
  logic             acc;
  logic             clear;
  logic             last;

`ifdef PROG_LOADER_CHECKSUM_EN
  localparam state_t FINAL = CHECK;
  logic [BYTE_W-1:0] csum;
`else
  localparam state_t FINAL = DONE;
`endif

  assign acc    = rx_valid && rx_ready;
  assign clear  = start && (st inside {IDLE, DONE, ERROR});
  assign len_in = {len[LEN_W-1:BYTE_W], rx_data};

  assign mem_addr = wcnt[ADDR_W-1:0];

  prog_word_packer u_pack (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .byte_in    (rx_data),
    .byte_valid (acc && st == DATA),
    .last       (last),
    .word       (mem_wdata),
    .word_valid (mem_we)
  );

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:   if (start) nxt = LEN_HI;
      LEN_HI: if (acc) nxt = LEN_LO;
      LEN_LO:
        if (acc) begin
          if ({1'b0, len_in} > CNT_W'(MAX_WORDS))
            nxt = ERROR;
          else if (len_in == '0)
            nxt = FINAL;
          else
            nxt = DATA;
        end
      DATA:
        if (acc && last && (wcnt + 1'b1) == {1'b0, len})
          nxt = FINAL;
`ifdef PROG_LOADER_CHECKSUM_EN
      CHECK:  if (acc) nxt = (rx_data == csum) ? DONE : ERROR;
`endif
      DONE:   if (start) nxt = LEN_HI;
      ERROR:  if (start) nxt = LEN_HI;
      default: nxt = IDLE;
    endcase
  end

  // status outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (!rst) begin
      st       <= IDLE;
      rx_ready <= 1'b0;
      cpu_rst  <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      len      <= '0;
      wcnt     <= '0;
    end else begin
      st       <= nxt;
      rx_ready <= rx_state(nxt);
      cpu_rst  <= (nxt != DONE);
      done     <= (nxt == DONE);
      err      <= (nxt == ERROR);
      if (acc && st == LEN_HI) len[LEN_W-1:BYTE_W] <= rx_data;
      if (acc && st == LEN_LO) len[BYTE_W-1:0] <= rx_data;
      if (clear)
        wcnt <= '0;
      else if (mem_we)
        wcnt <= wcnt + 1'b1;
    end
  end

`ifdef PROG_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!rst)
      csum <= '0;
    else if (clear)
      csum <= '0;
    else if (acc && st != CHECK)
      csum <= csum ^ rx_data;
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed image loads with a write scoreboard.
// Honours PROG_LOADER_CHECKSUM_EN when the RTL is built with it.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_rst;
  logic        done;
  logic        err;

  int pass_n = 0;
  int total_n = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t        exp_q[$];
  logic [7:0] sum;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] csum_flip = 8'h00;
`endif

  always #5 clk = ~clk;

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .err       (err)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  // monitor: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    if (mem_we !== 1'b0) begin
      if (exp_q.size() == 0) begin
        total_n++;
        $display("FAIL unexpected_we: addr %0h data %0h, none expected",
                 mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", mem_wdata, e.data);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input bit gap);
    int n = 0;
    if (gap) @(negedge clk);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      total_n++;
      $display("FAIL rx_ready_timeout: byte %0h never accepted", b);
      rx_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    sum = sum ^ b;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic load_a(input bit gap, input int nbytes);
    logic [7:0] img [10] = '{8'h00, 8'h02, 8'h13, 8'h00, 8'h10,
                             8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
    exp_q.push_back('{addr: 8'd0, data: 32'h00100013});
    if (nbytes >= 10)
      exp_q.push_back('{addr: 8'd1, data: 32'h00200093});
    sum = 8'h00;
    for (int i = 0; i < nbytes; i++) send(img[i], gap);
`ifdef PROG_LOADER_CHECKSUM_EN
    if (nbytes >= 10) send(sum ^ csum_flip, gap);
`endif
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 1);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
  endtask

  task automatic chk_status(input string tag, input bit d, input bit e);
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_err"}, 32'(err), 32'(e));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!d));
    chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
    chk({tag, "_drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst = 1'b1;
    @(negedge clk);
    chk("idle_rx_ready", 32'(rx_ready), 0);
    chk("idle_cpu_rst", 32'(cpu_rst), 1);

    pulse_start();
    chk("lenhi_rx_ready", 32'(rx_ready), 1);
    load_a(1'b0, 10);
    chk_status("img_a", 1'b1, 1'b0);

    // restart from DONE, then the same image with rx_valid gapped
    pulse_start();
    chk("restart_done", 32'(done), 0);
    chk("restart_cpu_rst", 32'(cpu_rst), 1);
    chk("restart_rx_ready", 32'(rx_ready), 1);
    load_a(1'b1, 10);
    chk_status("img_gap", 1'b1, 1'b0);

    // 0x0101 words exceeds 256
    pulse_start();
    sum = 8'h00;
    send(8'h01, 1'b0);
    send(8'h01, 1'b0);
    chk_status("too_long", 1'b0, 1'b1);

    // reset with a partial second word buffered
    pulse_start();
    load_a(1'b0, 7);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset("midload");
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midload_idle_ready", 32'(rx_ready), 0);
    pulse_start();
    load_a(1'b0, 10);
    chk_status("reload", 1'b1, 1'b0);

    // zero-length image
    pulse_start();
    sum = 8'h00;
    send(8'h00, 1'b0);
    send(8'h00, 1'b0);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(sum, 1'b0);
`endif
    chk_status("zero_len", 1'b1, 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    pulse_start();
    csum_flip = 8'h01;
    load_a(1'b0, 10);
    csum_flip = 8'h00;
    chk_status("bad_csum", 1'b0, 1'b1);
`endif

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule
